// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: walks each instruction through fetch, decode,
// execute, memory and write-back, and counts retired instructions.
module instr_sequencer (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic        HLT,
    input  logic        IS_LD,
    input  logic        IS_ST,
    input  logic        IS_BR,
    input  logic        IS_HALT,
    input  logic        BR_TAKEN,
    input  logic        MEM_RDY,
    output logic        MEM_REQ,
    output logic        MEM_WE,
    output logic        IR_LD,
    output logic        PC_LD,
    output logic        PC_SEL,
    output logic        REG_WE,
    output logic [2:0]  STATE,
    output logic [15:0] INSTR_CNT
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] instr_cnt_q, instr_cnt_d;

    always_comb begin
        // NOTE: every output and next-state value gets a default first, so no path through the case can infer a latch.
        state_d = state_q;
        MEM_REQ = 1'b0;
        MEM_WE  = 1'b0;
        IR_LD   = 1'b0;
        PC_LD   = 1'b0;
        PC_SEL  = 1'b0;
        REG_WE  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (START) state_d = S_FETCH;
            end
            S_FETCH: begin
                MEM_REQ = 1'b1;
                if (MEM_RDY) begin
                    IR_LD   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = IS_HALT ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                if (IS_LD || IS_ST) begin
                    state_d = S_MEM;
                end else if (IS_BR) begin
                    PC_LD   = 1'b1;
                    PC_SEL  = BR_TAKEN;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                // A load outranks a store when both class bits are set.
                MEM_REQ = 1'b1;
                MEM_WE  = !IS_LD;
                if (MEM_RDY) begin
                    if (IS_LD) begin
                        state_d = S_WB;
                    end else begin
                        PC_LD   = 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_WB: begin
                REG_WE  = 1'b1;
                PC_LD   = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT: begin
                if (START && !HLT) state_d = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase

        // Every PC update is an instruction boundary where an external halt is taken.
        if (PC_LD && HLT) state_d = S_HALT;

        instr_cnt_d = instr_cnt_q + {15'd0, PC_LD};
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= S_IDLE;
            instr_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign STATE     = state_q;
    assign INSTR_CNT = instr_cnt_q;

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port RST, input, 1; reset is asynchronous and active-high.
REQ-003 SHALL have port START, input, 1: leave IDLE or HALT and begin fetching.
REQ-004 SHALL have port HLT, input, 1: external halt request, honoured at the next instruction boundary.
REQ-005 SHALL have ports IS_LD, IS_ST, IS_BR, IS_HALT, input, 1 each: decoded class of the instruction held in IR, valid from DECODE onward.
REQ-006 SHALL have port BR_TAKEN, input, 1: branch condition result, sampled in EXEC.
REQ-007 SHALL have port MEM_RDY, input, 1: memory completes the current request in this cycle.
REQ-008 SHALL have ports MEM_REQ and MEM_WE, output, 1 each: memory request and write strobe.
REQ-009 SHALL have ports IR_LD, PC_LD, PC_SEL and REG_WE, output, 1 each: IR load, PC update, PC source (1 = branch target, 0 = PC+1) and register-file write.
REQ-010 SHALL have port STATE, output, 3: current state code.
REQ-011 SHALL have port INSTR_CNT, output, 16: retired-instruction count.

Function
REQ-012 SHALL encode states as IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6; codes 7 SHALL go to IDLE on the next edge.
REQ-013 IDLE: all strobes 0; START=1 -> FETCH.
REQ-014 FETCH: MEM_REQ=1, MEM_WE=0; if MEM_RDY=0, stay; if MEM_RDY=1, IR_LD=1 in that cycle and go to DECODE.
REQ-015 DECODE: IS_HALT=1 -> HALT; otherwise -> EXEC; no strobes.
REQ-016 EXEC, branch case: if IS_LD=1 or IS_ST=1 -> MEM; else if IS_BR=1, PC_LD=1, PC_SEL=BR_TAKEN and go to FETCH.
REQ-017 EXEC, ALU case: otherwise -> WB.
REQ-018 MEM: MEM_REQ=1, MEM_WE=IS_ST; stay while MEM_RDY=0.
REQ-019 MEM, completion: on MEM_RDY=1, a load goes to WB; a store asserts PC_LD=1, PC_SEL=0 and goes to FETCH.
REQ-020 WB: REG_WE=1, PC_LD=1, PC_SEL=0, for exactly one cycle; then -> FETCH.
REQ-021 HALT: all strobes 0; START=1 with HLT=0 -> FETCH; START with HLT=1 stays in HALT.
REQ-022 An instruction boundary is any cycle in which PC_LD=1. If HLT=1 in that cycle, next state SHALL be HALT instead of FETCH; the PC update still occurs.
REQ-023 HLT SHALL NOT abort FETCH, DECODE, EXEC, MEM or WB.
REQ-024 All strobe outputs SHALL be combinational from state and inputs; IR_LD and PC_LD SHALL be single-cycle pulses.
REQ-025 INSTR_CNT SHALL increment by 1 on every cycle with PC_LD=1, wrapping from 0xFFFF to 0x0000.
REQ-026 An IS_HALT instruction SHALL NOT increment INSTR_CNT and SHALL NOT assert PC_LD.
REQ-027 Class inputs with more than one bit set SHALL take priority IS_LD > IS_ST > IS_BR.
REQ-028 MEM_RDY SHALL be ignored outside FETCH and MEM.

Reset
REQ-029 On RST=1 (any cycle, including mid-MEM wait), STATE SHALL become IDLE and INSTR_CNT SHALL become 0 immediately.
REQ-030 On RST=1, all strobe outputs SHALL be 0 while RST is held.
REQ-031 After RST is released, the block SHALL remain in IDLE until START=1.

Verification
REQ-032 ALU instruction: START pulse, MEM_RDY tied 1, all class inputs 0 -> STATE sequence 1,2,3,5,1. IR_LD=1 in the FETCH cycle; REG_WE=1 and PC_LD=1 in WB; INSTR_CNT=1.
REQ-033 Load with memory wait: IS_LD=1, MEM_RDY=0 for 2 MEM cycles then 1 -> MEM_REQ=1 and MEM_WE=0 for 3 cycles, then WB with REG_WE=1.
REQ-034 Store: IS_ST=1 -> MEM_WE=1 in MEM, PC_LD=1 on MEM_RDY, no WB.
REQ-035 Branch: IS_BR=1 -> PC_LD=1 in EXEC with PC_SEL=1 when BR_TAKEN=1 and PC_SEL=0 when BR_TAKEN=0.
REQ-036 Halt instruction: IS_HALT=1 -> STATE 2 then 6, with INSTR_CNT unchanged.
REQ-037 External halt: HLT=1 raised during WB -> STATE=6 next, with the PC_LD pulse present.
REQ-038 Resume: START with HLT=0 -> STATE=1.
REQ-039 Reset and wrap: RST asserted mid-MEM wait -> STATE=0 and INSTR_CNT=0 immediately; INSTR_CNT preloaded to 0xFFFF by 65535 retirements plus one more -> 0x0000.
